hora_seg_decoder: RTL and testbench
===================================

// Module: hora_seg_decoder
// PURPOSE
//  Receive end of the hour display path: samples the two active-low 7-segment buses driven by the
//  hour counter (units + tens), decodes them back to a binary hour 0..23, filters glitches and
//  reports validated hour, step/rollover/jump events and illegal patterns. Feeds the alarm compare
//  and display self-check logic.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples needed before a pattern is accepted (>=1)
//  MAX_HOUR       23  highest legal hour; decoded values above it are errors
// PORTS
//  clock      in   1  system clock, all logic on posedge
//  zera_n     in   1  asynchronous active-low reset
//  seg_units  in   7  units digit segments {a,b,c,d,e,f,g}, active-low (0 = lit)
//  seg_tens   in   7  tens digit segments {a,b,c,d,e,f,g}, active-low
//  err_clr    in   1  synchronous clear of sticky err
//  hour       out  5  last accepted legal hour, binary
//  hour_valid out  1  high while in LOCKED
//  step       out  1  1-cycle pulse: accepted hour == previous+1 (no wrap)
//  day_tick   out  1  1-cycle pulse: accepted 0 while previous accepted was MAX_HOUR
//  jump       out  1  1-cycle pulse: accepted legal hour that is neither same, +1, nor wrap
//  err        out  1  sticky: an illegal pattern or value > MAX_HOUR was accepted
// BEHAVIOUR
//  - Reset values: hour=0, hour_valid=0, step=0, day_tick=0, jump=0, err=0, state=INIT,
//    both input stages=7'h7F (blank), stability counter=0.
//  - Input: seg_tens/seg_units registered through 2 flop stages (metastability; pins may be off-board).
//  - Digit patterns (a..g): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//    6=0100000 7=0001111 8=0000000 9=0000100. Any other 7-bit value is illegal.
//  - Stability: cand = {tens,units} at stage-2 output. If cand != previous stage-2 value, counter<=0;
//    else counter saturates at STABLE_CYCLES-1. Accept in the cycle counter reaches STABLE_CYCLES-1
//    (exactly once per stable run; no re-accept while held). Outputs change on the following edge:
//    latency pin->outputs = STABLE_CYCLES+2 clocks for a pattern held unchanged.
//  - Decoded value = 10*tens+units, 7-bit arithmetic; legal iff both digits legal and value<=MAX_HOUR.
//  - FSM: INIT (nothing accepted) / LOCKED (hour valid) / FAULT (last accept illegal).
//    INIT  -legal-> LOCKED (hour<=value, no event pulse); -illegal-> FAULT, err<=1.
//    LOCKED-legal-> LOCKED, hour<=value, pulse per rules; -illegal-> FAULT, err<=1, hour held.
//    FAULT -legal-> LOCKED, hour<=value, no event pulse (history lost); -illegal-> FAULT.
//  - Event rules in LOCKED: same value -> no pulse; prev+1 (prev<MAX_HOUR) -> step;
//    prev==MAX_HOUR & value==0 -> day_tick; else -> jump (covers counter clear to 0 mid-day).
//    At most one of step/day_tick/jump high in any cycle.
//  - err_clr: err<=0 unless an illegal accept occurs same cycle (set wins). err_clr does not
//    change state.
//  - Blank bus (7'h7F) is illegal like any unknown pattern.
//  - zera_n asserted mid-stabilisation discards candidate; any time, async to reset values.
// STRUCTURE
//  - Shared package hora_pkg: SEG_0..SEG_9 and SEG_BLANK constants (active-low a..g), state
//    encodings INIT/LOCKED/FAULT, MAX_HOUR default. The hour counter's encoder uses the same table.
//  - One combinational sub-module seg7_to_bcd: 7-bit pattern -> {legal, digit[3:0]}, instanced
//    twice. Sync, stability counter, FSM and event logic stay in this module.
// TESTING
//  1 Reset, hold "00" for 6 cycles -> hour=0, hour_valid=1 at cycle 6 (STABLE_CYCLES=4), no pulses.
//  2 From LOCKED 09, drive "10" stable -> step one cycle, hour=10; hold 20 cycles -> no repeat.
//  3 From 23, drive "00" -> day_tick one cycle, hour=0; from 15 drive "00" -> jump, hour=0.
//  4 From 12, glitch "13" for 3 cycles then back "12" -> no accept, hour stays 12, no pulses.
//  5 Drive tens=2,units=5 ("25") stable -> err=1, hour_valid=0, hour=prev; then "06" -> LOCKED,
//    hour=6, no pulse, err still 1; err_clr -> err=0.
//  6 Pull zera_n low at counter=2 mid-run -> all outputs reset immediately; release, "07" -> hour=7.

Source files
------------

// File: rtl/hora_pkg.sv
// Shared definitions for the hour display path.
// Holds the active-low 7-segment table {a,b,c,d,e,f,g}, the decoder states,
// the sub-module output payload and the default parameters.
package hora_pkg;

  localparam int unsigned SEG_W              = 7;
  localparam int unsigned HOUR_W             = 5;
  localparam int unsigned VAL_W              = 7;
  localparam int unsigned MAX_HOUR_DEF       = 23;
  localparam int unsigned STABLE_CYCLES_DEF  = 4;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // Decoded digit: legal flag plus BCD value
  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } digit_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational active-low 7-segment to BCD decoder.
// Ports: seg (7-bit pattern {a..g}, 0 = lit) -> dec {legal, digit[3:0]}.
// Unknown patterns, including a blank bus, decode as illegal with digit 0.
module seg7_to_bcd
  import hora_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output digit_t           dec
);

  always_comb begin
    dec.legal = 1'b1;
    dec.digit = 4'd0;
    case (seg)
      SEG_0:   dec.digit = 4'd0;
      SEG_1:   dec.digit = 4'd1;
      SEG_2:   dec.digit = 4'd2;
      SEG_3:   dec.digit = 4'd3;
      SEG_4:   dec.digit = 4'd4;
      SEG_5:   dec.digit = 4'd5;
      SEG_6:   dec.digit = 4'd6;
      SEG_7:   dec.digit = 4'd7;
      SEG_8:   dec.digit = 4'd8;
      SEG_9:   dec.digit = 4'd9;
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/hora_seg_decoder.sv
// Receive side of the hour display: decodes two active-low 7-segment buses
// back to a binary hour, debounces them and reports hour events.
// Ports: clock, zera_n (async active-low reset), seg_units/seg_tens (7-bit
// active-low), err_clr (sync clear of sticky err); outputs hour[4:0],
// hour_valid, step, day_tick, jump (1-cycle pulses), err (sticky).
module hora_seg_decoder
  import hora_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_HOUR      = MAX_HOUR_DEF
) (
  input  logic              clock,
  input  logic              zera_n,
  input  logic [SEG_W-1:0]  seg_units,
  input  logic [SEG_W-1:0]  seg_tens,
  input  logic              err_clr,
  output logic [HOUR_W-1:0] hour,
  output logic              hour_valid,
  output logic              step,
  output logic              day_tick,
  output logic              jump,
  output logic              err
);

  localparam int unsigned        CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2*SEG_W-1:0] BLANK2  = {SEG_BLANK, SEG_BLANK};

  // {tens, units} synchroniser stages and previous stage-2 sample
  logic [2*SEG_W-1:0] sync1, sync2, prev;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               done;
  logic               same_c, accept_c;

  digit_t             dec_tens, dec_units;
  logic [VAL_W-1:0]   value_c;
  logic               legal_c;

  state_t             state, state_nxt;
  logic [HOUR_W-1:0]  hour_nxt;
  logic               step_nxt, day_tick_nxt, jump_nxt, err_nxt;

  // Two-flop input sync plus stability counter; done blocks re-accept while held
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      sync1 <= BLANK2;
      sync2 <= BLANK2;
      prev  <= BLANK2;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      sync1 <= {seg_tens, seg_units};
      sync2 <= sync1;
      prev  <= sync2;
      cnt   <= cnt_nxt;
      done  <= same_c & (done | accept_c);
    end
  end

  // Accept fires in the cycle the saturating counter reaches its top value
  always_comb begin
    same_c  = (sync2 == prev);
    cnt_nxt = '0;
    if (same_c) begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
    accept_c = same_c & ~done & (cnt_nxt == CNT_MAX);
  end

  seg7_to_bcd u_tens (
    .seg (sync2[2*SEG_W-1:SEG_W]),
    .dec (dec_tens)
  );

  seg7_to_bcd u_units (
    .seg (sync2[SEG_W-1:0]),
    .dec (dec_units)
  );

  // Binary value of the candidate; out-of-range values count as illegal
  always_comb begin
    value_c = VAL_W'(dec_tens.digit) * VAL_W'(10) + VAL_W'(dec_units.digit);
    legal_c = dec_tens.legal & dec_units.legal & (value_c <= VAL_W'(MAX_HOUR));
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      state      <= INIT;
      hour       <= '0;
      hour_valid <= 1'b0;
      step       <= 1'b0;
      day_tick   <= 1'b0;
      jump       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      hour       <= hour_nxt;
      hour_valid <= (state_nxt == LOCKED);
      step       <= step_nxt;
      day_tick   <= day_tick_nxt;
      jump       <= jump_nxt;
      err        <= err_nxt;
    end
  end

  // Next state, hour and events; an illegal accept overrides err_clr
  always_comb begin
    state_nxt    = state;
    hour_nxt     = hour;
    step_nxt     = 1'b0;
    day_tick_nxt = 1'b0;
    jump_nxt     = 1'b0;
    err_nxt      = err_clr ? 1'b0 : err;
    if (accept_c) begin
      if (legal_c) begin
        state_nxt = LOCKED;
        hour_nxt  = HOUR_W'(value_c);
        // Events only when history is trusted
        if (state == LOCKED) begin
          if (value_c == VAL_W'(hour)) begin
            step_nxt = 1'b0;
          end else if ((hour < HOUR_W'(MAX_HOUR)) &&
                       (value_c == VAL_W'(hour) + VAL_W'(1))) begin
            step_nxt = 1'b1;
          end else if ((hour == HOUR_W'(MAX_HOUR)) && (value_c == '0)) begin
            day_tick_nxt = 1'b1;
          end else begin
            jump_nxt = 1'b1;
          end
        end
      end else begin
        state_nxt = FAULT;
        err_nxt   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hora_seg_decoder.sv
// Self-checking bench for hora_seg_decoder: a reference model predicts the
// outputs for each pattern, queued at drive time and compared at accept time.
module tb_hora_seg_decoder;

  localparam int unsigned SC   = 4;
  localparam int unsigned MAXH = 23;
  localparam int unsigned LAT  = SC + 2;

  logic       clock = 1'b0;
  logic       zera_n;
  logic       err_clr;
  logic [6:0] seg_units, seg_tens;
  logic [4:0] hour;
  logic       hour_valid, step, day_tick, jump, err;

  typedef struct packed {
    logic [4:0] hour;
    logic       valid;
    logic       step;
    logic       day_tick;
    logic       jump;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Reference model state: 0 = init, 1 = locked, 2 = fault
  logic [4:0] m_hour;
  int         m_state;
  logic       m_err;

  hora_seg_decoder #(.STABLE_CYCLES(SC), .MAX_HOUR(MAXH)) dut (
    .clock      (clock),
    .zera_n     (zera_n),
    .seg_units  (seg_units),
    .seg_tens   (seg_tens),
    .err_clr    (err_clr),
    .hour       (hour),
    .hour_valid (hour_valid),
    .step       (step),
    .day_tick   (day_tick),
    .jump       (jump),
    .err        (err)
  );

  always #5 clock = ~clock;

  function automatic obs_t observe();
    return {hour, hour_valid, step, day_tick, jump, err};
  endfunction

  function automatic obs_t quiet();
    obs_t r;
    r          = '0;
    r.hour     = m_hour;
    r.valid    = (m_state == 1);
    r.err      = m_err;
    return r;
  endfunction

  function automatic void model_reset();
    m_hour  = '0;
    m_state = 0;
    m_err   = 1'b0;
  endfunction

  // Applies one accepted pattern to the model and returns the expected outputs
  function automatic obs_t predict(input logic [6:0] t_raw, input logic [6:0] u_raw);
    obs_t r;
    int   t, u, v;
    r = '0;
    t = -1;
    u = -1;
    for (int i = 0; i < 10; i++) begin
      if (pat[i] == t_raw) t = i;
      if (pat[i] == u_raw) u = i;
    end
    v = t * 10 + u;
    if (t >= 0 && u >= 0 && v <= int'(MAXH)) begin
      if (m_state == 1) begin
        if (v == int'(m_hour)) r.step = 1'b0;
        else if (int'(m_hour) < int'(MAXH) && v == int'(m_hour) + 1) r.step = 1'b1;
        else if (int'(m_hour) == int'(MAXH) && v == 0) r.day_tick = 1'b1;
        else r.jump = 1'b1;
      end
      m_hour  = 5'(v);
      m_state = 1;
    end else begin
      m_state = 2;
      m_err   = 1'b1;
    end
    r.hour  = m_hour;
    r.valid = (m_state == 1);
    r.err   = m_err;
    return r;
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_raw(input logic [6:0] t_raw, input logic [6:0] u_raw);
    seg_tens  = t_raw;
    seg_units = u_raw;
    exp_q.push_back(predict(t_raw, u_raw));
  endtask

  task automatic send(input int t, input int u);
    send_raw(pat[t], pat[u]);
  endtask

  task automatic test_reset();
    obs_t e;
    zera_n    = 1'b0;
    err_clr   = 1'b0;
    seg_tens  = pat[0];
    seg_units = pat[0];
    model_reset();
    wait_neg(3);
    checks++;
    if (observe() !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_values got %h want %h", observe(), obs_t'(0));
    end
    zera_n = 1'b1;
    exp_q.push_back(predict(pat[0], pat[0]));
    wait_neg(LAT - 1);
    checks++;
    if (observe() !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_early_accept got %h want %h", observe(), obs_t'(0));
    end
    wait_neg(1);
    e = exp_q.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL reset_first_lock got %h want %h", observe(), e);
    end
    wait_neg(1);
    checks++;
    if (observe() !== quiet()) begin
      errors++;
      $display("FAIL reset_hold got %h want %h", observe(), quiet());
    end
  endtask

  task automatic test_step();
    int   tt[2] = '{0, 1};
    int   uu[2] = '{9, 0};
    obs_t pre, e;
    for (int k = 0; k < 2; k++) begin
      pre = quiet();
      send(tt[k], uu[k]);
      wait_neg(LAT - 1);
      checks++;
      if (observe() !== pre) begin
        errors++;
        $display("FAIL step_early k=%0d got %h want %h", k, observe(), pre);
      end
      wait_neg(1);
      e = exp_q.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL step_accept k=%0d got %h want %h", k, observe(), e);
      end
    end
    for (int c = 0; c < 20; c++) begin
      wait_neg(1);
      checks++;
      if (observe() !== quiet()) begin
        errors++;
        $display("FAIL step_no_repeat c=%0d got %h want %h", c, observe(), quiet());
      end
    end
  endtask

  task automatic test_day_tick();
    int   tt[4] = '{2, 0, 1, 0};
    int   uu[4] = '{3, 0, 5, 0};
    obs_t pre, e;
    for (int k = 0; k < 4; k++) begin
      pre = quiet();
      send(tt[k], uu[k]);
      wait_neg(LAT - 1);
      checks++;
      if (observe() !== pre) begin
        errors++;
        $display("FAIL wrap_early k=%0d got %h want %h", k, observe(), pre);
      end
      wait_neg(1);
      e = exp_q.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL wrap_accept k=%0d got %h want %h", k, observe(), e);
      end
      wait_neg(1);
      checks++;
      if (observe() !== quiet()) begin
        errors++;
        $display("FAIL wrap_pulse_len k=%0d got %h want %h", k, observe(), quiet());
      end
    end
  endtask

  task automatic test_glitch();
    obs_t e;
    send(1, 2);
    wait_neg(LAT);
    e = exp_q.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL glitch_setup got %h want %h", observe(), e);
    end
    wait_neg(1);
    seg_tens  = pat[1];
    seg_units = pat[3];
    wait_neg(3);
    seg_tens  = pat[1];
    seg_units = pat[2];
    for (int c = 0; c < 15; c++) begin
      wait_neg(1);
      checks++;
      if (observe() !== quiet()) begin
        errors++;
        $display("FAIL glitch_ignored c=%0d got %h want %h", c, observe(), quiet());
      end
    end
  endtask

  task automatic test_error();
    int   tt[2] = '{2, 0};
    int   uu[2] = '{5, 6};
    obs_t pre, e;
    for (int k = 0; k < 2; k++) begin
      pre = quiet();
      send(tt[k], uu[k]);
      wait_neg(LAT - 1);
      checks++;
      if (observe() !== pre) begin
        errors++;
        $display("FAIL err_early k=%0d got %h want %h", k, observe(), pre);
      end
      wait_neg(1);
      e = exp_q.pop_front();
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL err_accept k=%0d got %h want %h", k, observe(), e);
      end
    end
    err_clr = 1'b1;
    wait_neg(1);
    err_clr = 1'b0;
    m_err   = 1'b0;
    checks++;
    if (observe() !== quiet()) begin
      errors++;
      $display("FAIL err_clear got %h want %h", observe(), quiet());
    end
    // Blank bus accepted while err_clr is high: set must win
    pre = quiet();
    send_raw(7'h7F, 7'h7F);
    wait_neg(LAT - 1);
    checks++;
    if (observe() !== pre) begin
      errors++;
      $display("FAIL blank_early got %h want %h", observe(), pre);
    end
    err_clr = 1'b1;
    wait_neg(1);
    err_clr = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL blank_set_wins got %h want %h", observe(), e);
    end
    // Digits legal but value out of range stays in fault
    send(9, 9);
    wait_neg(LAT);
    e = exp_q.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL over_range got %h want %h", observe(), e);
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    seg_tens  = pat[0];
    seg_units = pat[8];
    wait_neg(5);
    zera_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (observe() !== obs_t'(0)) begin
      errors++;
      $display("FAIL async_reset got %h want %h", observe(), obs_t'(0));
    end
    wait_neg(2);
    seg_tens  = pat[0];
    seg_units = pat[7];
    zera_n    = 1'b1;
    exp_q.push_back(predict(pat[0], pat[7]));
    wait_neg(LAT - 1);
    checks++;
    if (observe() !== obs_t'(0)) begin
      errors++;
      $display("FAIL rst_early got %h want %h", observe(), obs_t'(0));
    end
    wait_neg(1);
    e = exp_q.pop_front();
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL rst_relock got %h want %h", observe(), e);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_day_tick();
    test_glitch();
    test_error();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
